// File: rtl/cmd_exec_ctrl_if.sv
// Instruction/register-file bus between the command sequencer and the datapath.
// master = sequencer side, slave = ROM + register file + PC side.
interface cmd_exec_ctrl_if;
  logic [7:0] instr;
  logic [7:0] R0;
  logic [7:0] R1;
  logic [7:0] R2;
  logic [7:0] R3;
  logic [7:0] res_alu;
  logic [1:0] res_dest;
  logic       enact;
  logic       pc_inc;

  modport master (
    input  instr, R0, R1, R2, R3,
    output res_alu, res_dest, enact, pc_inc
  );

  modport slave (
    output instr, R0, R1, R2, R3,
    input  res_alu, res_dest, enact, pc_inc
  );
endinterface

// File: rtl/cmd_exec_ctrl.sv
// Fetch/decode/execute sequencer for the 4-register datapath: one instruction
// every five cycles (FETCH, DECODE, EXEC, WB, NEXT), registered write-back and PC pulse.
module cmd_exec_ctrl (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   run,
  cmd_exec_ctrl_if.master        bus,
  output logic                   busy,
  output logic                   halted,
  output logic                   flag_c,
  output logic                   flag_z
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_NEXT, S_HALT
  } state_t;

  state_t      state_q;
  logic [7:0]  ir_q;
  logic [7:0]  a_q, b_q;
  logic [7:0]  res_alu_q;
  logic [1:0]  res_dest_q;
  logic        enact_q, pc_inc_q, busy_q, halted_q, flag_c_q, flag_z_q;

  logic [3:0]  op;
  logic [7:0]  a_d, b_d;
  logic [7:0]  alu_res;
  logic        alu_c, c_upd, wr_op;

  assign op = ir_q[7:4];

  always_comb begin
    case (ir_q[3:2])
      2'd0:    a_d = bus.R0;
      2'd1:    a_d = bus.R1;
      2'd2:    a_d = bus.R2;
      default: a_d = bus.R3;
    endcase
    case (ir_q[1:0])
      2'd0:    b_d = bus.R0;
      2'd1:    b_d = bus.R1;
      2'd2:    b_d = bus.R2;
      default: b_d = bus.R3;
    endcase
  end

  // ALU: carry/borrow comes from the 9th bit; c_upd marks ops that own the carry flag.
  always_comb begin
    alu_res = 8'h00;
    alu_c   = flag_c_q;
    c_upd   = 1'b0;
    wr_op   = (op != 4'h0) && (op <= 4'hB);
    case (op)
      4'h1: alu_res = b_q;
      4'h2: begin {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q}; c_upd = 1'b1; end
      4'h3: begin {alu_c, alu_res} = {1'b0, a_q} - {1'b0, b_q}; c_upd = 1'b1; end
      4'h4: alu_res = a_q & b_q;
      4'h5: alu_res = a_q | b_q;
      4'h6: alu_res = a_q ^ b_q;
      4'h7: alu_res = ~b_q;
      4'h8: begin alu_res = {b_q[6:0], 1'b0}; alu_c = b_q[7]; c_upd = 1'b1; end
      4'h9: begin alu_res = {1'b0, b_q[7:1]}; alu_c = b_q[0]; c_upd = 1'b1; end
      4'hA: begin {alu_c, alu_res} = {1'b0, a_q} + 9'd1; c_upd = 1'b1; end
      4'hB: begin {alu_c, alu_res} = {1'b0, a_q} - 9'd1; c_upd = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      ir_q       <= 8'h00;
      res_alu_q  <= 8'h00;
      res_dest_q <= 2'd0;
      enact_q    <= 1'b0;
      pc_inc_q   <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      flag_z_q   <= 1'b0;
    end else begin
      enact_q  <= 1'b0;
      pc_inc_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          ir_q    <= bus.instr;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          a_q     <= a_d;
          b_q     <= b_d;
          state_q <= S_EXEC;
        end
        // Result and flags are latched here so they are stable throughout WB.
        S_EXEC: begin
          if (op == 4'hF) begin
            state_q  <= S_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q    <= S_WB;
            res_dest_q <= ir_q[3:2];
            if (wr_op) begin
              res_alu_q <= alu_res;
              flag_z_q  <= (alu_res == 8'h00);
              enact_q   <= 1'b1;
            end
            if (c_upd) flag_c_q <= alu_c;
          end
        end
        S_WB: begin
          state_q  <= S_NEXT;
          pc_inc_q <= 1'b1;
        end
        S_NEXT: begin
          if (run) begin
            state_q <= S_FETCH;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_HALT: ;
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.res_alu  = res_alu_q;
  assign bus.res_dest = res_dest_q;
  assign bus.enact    = enact_q;
  assign bus.pc_inc   = pc_inc_q;
  assign busy         = busy_q;
  assign halted       = halted_q;
  assign flag_c       = flag_c_q;
  assign flag_z       = flag_z_q;

endmodule

// File: tb/tb_cmd_exec_ctrl.sv
// Bench for cmd_exec_ctrl: vector table through a scoreboard queue, plus
// hand-written run-drop, HALT and clr-mid-instruction sequences.
module tb_cmd_exec_ctrl;
  logic clk = 1'b0;
  logic clr, run;
  logic busy, halted, flag_c, flag_z;

  cmd_exec_ctrl_if bus();

  cmd_exec_ctrl dut (
    .clk    (clk),
    .clr    (clr),
    .run    (run),
    .bus    (bus),
    .busy   (busy),
    .halted (halted),
    .flag_c (flag_c),
    .flag_z (flag_z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] instr;
    logic [7:0] r0, r1, r2, r3;
    logic [7:0] res;
    logic [1:0] dest;
    logic       en, c, z;
  } vec_t;

  vec_t       tbl[$];
  vec_t       exp_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] cur_instr = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s instr=%h actual=%0h required=%0h", name, cur_instr, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] instr, r0, r1, r2, r3, res,
                              input logic [1:0] dest, input logic en, c, z);
    vec_t v;
    v.instr = instr; v.r0 = r0; v.r1 = r1; v.r2 = r2; v.r3 = r3;
    v.res = res; v.dest = dest; v.en = en; v.c = c; v.z = z;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    cur_instr = v.instr;
    bus.instr = v.instr;
    bus.R0 = v.r0; bus.R1 = v.r1; bus.R2 = v.r2; bus.R3 = v.r3;
  endtask

  // Called at a negedge in IDLE or NEXT; returns at the negedge of the NEXT cycle.
  task automatic do_instr(input vec_t v, input int drop_at);
    vec_t       e;
    int         en_cyc = 0;
    int         pc_cyc = 0;
    logic [7:0] res_s = 8'h00;
    logic [1:0] dest_s = 2'd0;
    drive(v);
    exp_q.push_back(v);
    for (int k = 1; k <= 8 && pc_cyc == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == drop_at) run = 1'b0;
      chk("busy_in_instr", {31'd0, busy}, 32'd1);
      chk("enact_pc_excl", {31'd0, bus.enact & bus.pc_inc}, 32'd0);
      if (bus.enact) begin
        chk("enact_once", en_cyc, 0);
        en_cyc = k;
        res_s  = bus.res_alu;
        dest_s = bus.res_dest;
      end
      if (bus.pc_inc) pc_cyc = k;
    end
    e = exp_q.pop_front();
    chk("pc_inc_cycle", pc_cyc, 5);
    chk("enact_cycle", en_cyc, e.en ? 4 : 0);
    if (e.en) begin
      chk("res_alu", {24'd0, res_s}, {24'd0, e.res});
      chk("res_dest", {30'd0, dest_s}, {30'd0, e.dest});
    end
    chk("flag_c", {31'd0, flag_c}, {31'd0, e.c});
    chk("flag_z", {31'd0, flag_z}, {31'd0, e.z});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_res_alu"}, {24'd0, bus.res_alu}, 32'd0);
    chk({tag, "_res_dest"}, {30'd0, bus.res_dest}, 32'd0);
    chk({tag, "_enact"}, {31'd0, bus.enact}, 32'd0);
    chk({tag, "_pc_inc"}, {31'd0, bus.pc_inc}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_flag_c"}, {31'd0, flag_c}, 32'd0);
    chk({tag, "_flag_z"}, {31'd0, flag_z}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog instr=%h simulation did not finish in time", cur_instr);
    $fatal(1);
  end

  initial begin
    //        instr  R0     R1     R2     R3     res    dest en c  z
    tbl.push_back(mk(8'h26, 8'h00, 8'h05, 8'h03, 8'h00, 8'h08, 2'd1, 1, 0, 0));
    tbl.push_back(mk(8'h21, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 2'd0, 1, 1, 1));
    tbl.push_back(mk(8'h3B, 8'h00, 8'h00, 8'h03, 8'h05, 8'hFE, 2'd2, 1, 1, 0));
    tbl.push_back(mk(8'hC5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 0, 1, 0));
    tbl.push_back(mk(8'h83, 8'h00, 8'h00, 8'h00, 8'h81, 8'h02, 2'd0, 1, 1, 0));
    tbl.push_back(mk(8'h1C, 8'h00, 8'h00, 8'h00, 8'h77, 8'h00, 2'd3, 1, 1, 1));
    tbl.push_back(mk(8'h46, 8'h00, 8'hF0, 8'h3C, 8'h00, 8'h30, 2'd1, 1, 1, 0));
    tbl.push_back(mk(8'h5B, 8'h00, 8'h00, 8'h0F, 8'hA0, 8'hAF, 2'd2, 1, 1, 0));
    tbl.push_back(mk(8'h65, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 2'd1, 1, 1, 1));
    tbl.push_back(mk(8'h72, 8'h00, 8'h00, 8'h0F, 8'h00, 8'hF0, 2'd0, 1, 1, 0));
    tbl.push_back(mk(8'h90, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 2'd0, 1, 0, 0));
    tbl.push_back(mk(8'hA4, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 2'd1, 1, 1, 1));
    tbl.push_back(mk(8'hB8, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 2'd2, 1, 1, 0));
    tbl.push_back(mk(8'hB8, 8'h00, 8'h00, 8'h10, 8'h00, 8'h0F, 2'd2, 1, 0, 0));
    tbl.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 0, 0, 0));
    tbl.push_back(mk(8'hA0, 8'h41, 8'h00, 8'h00, 8'h00, 8'h42, 2'd0, 1, 0, 0));
    tbl.push_back(mk(8'h31, 8'h07, 8'h07, 8'h00, 8'h00, 8'h00, 2'd0, 1, 0, 1));
    tbl.push_back(mk(8'hDF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 0, 0, 1));
    tbl.push_back(mk(8'hE2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 0, 0, 1));

    // Reset with run held high
    clr = 1'b1; run = 1'b1;
    drive(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    clr = 1'b0;

    foreach (tbl[i]) do_instr(tbl[i], 0);

    // run dropped in DECODE: instruction completes, then IDLE
    do_instr(mk(8'h26, 8'h00, 8'h05, 8'h03, 8'h00, 8'h08, 2'd1, 1, 0, 0), 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_pc_inc", {31'd0, bus.pc_inc}, 32'd0);
      chk("idle_enact", {31'd0, bus.enact}, 32'd0);
    end

    // HALT: no pc_inc, no enact, outputs hold until clr
    run = 1'b1;
    drive(mk(8'hF0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 2'd0, 0, 0, 0));
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("halt_halted", {31'd0, halted}, (k >= 4) ? 32'd1 : 32'd0);
      chk("halt_busy", {31'd0, busy}, (k >= 4) ? 32'd0 : 32'd1);
      chk("halt_pc_inc", {31'd0, bus.pc_inc}, 32'd0);
      chk("halt_enact", {31'd0, bus.enact}, 32'd0);
    end
    chk("halt_res_alu", {24'd0, bus.res_alu}, 32'h08);
    chk("halt_res_dest", {30'd0, bus.res_dest}, 32'd1);
    chk("halt_flag_c", {31'd0, flag_c}, 32'd0);
    chk("halt_flag_z", {31'd0, flag_z}, 32'd0);
    clr = 1'b1; run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("halt_clr");

    // clr during EXEC of an ADD
    clr = 1'b0; run = 1'b1;
    drive(mk(8'h26, 8'h00, 8'h05, 8'h03, 8'h00, 8'h08, 2'd1, 1, 0, 0));
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    clr = 1'b1; run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("clr_exec");
    clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("clr_exec_idle_busy", {31'd0, busy}, 32'd0);
      chk("clr_exec_idle_enact", {31'd0, bus.enact}, 32'd0);
    end

    // clr during WB: enact drops on the following cycle
    run = 1'b1;
    drive(mk(8'h21, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 2'd0, 1, 1, 1));
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("wb_enact", {31'd0, bus.enact}, 32'd1);
    chk("wb_res_alu", {24'd0, bus.res_alu}, 32'h00);
    chk("wb_flag_c", {31'd0, flag_c}, 32'd1);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("clr_wb_enact", {31'd0, bus.enact}, 32'd0);
    chk("clr_wb_pc_inc", {31'd0, bus.pc_inc}, 32'd0);
    chk("clr_wb_flag_c", {31'd0, flag_c}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
